// File: rtl/mem_arb_pkg.sv
// Shared types for the dual-port memory arbiter.
// Grant records and port names used by the picker and the top.
package mem_arb_pkg;

    // Requester index is sized for the largest supported requester count.
    localparam int MAX_REQ = 8;
    localparam int IDX_W   = $clog2(MAX_REQ);

    typedef struct packed {
        logic             vld;
        logic [IDX_W-1:0] idx;
        logic             we;
    } grant_t;

    typedef enum logic {
        PORT_A = 1'b0,
        PORT_B = 1'b1
    } port_e;

endpackage

// File: rtl/mem_arb_pick2.sv
// Ranks valid requesters (urgent first, then lowest index).
// Produces the two highest-ranked grants.
module mem_arb_pick2
    import mem_arb_pkg::*;
#(
    parameter int NUM_REQ = 3
) (
    input  logic [NUM_REQ-1:0] valid_i,
    input  logic [NUM_REQ-1:0] urgent_i,
    input  logic [NUM_REQ-1:0] we_i,
    output grant_t             first_o,
    output grant_t             second_o
);

    always_comb begin
        first_o  = '0;
        second_o = '0;
        // Pass 0 scans urgent requesters, pass 1 the rest.
        for (int pass = 0; pass < 2; pass++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (valid_i[i] && (urgent_i[i] == (pass == 0))) begin
                    if (!first_o.vld) begin
                        first_o.vld = 1'b1;
                        first_o.idx = IDX_W'(i);
                        first_o.we  = we_i[i];
                    end else if (!second_o.vld) begin
                        second_o.vld = 1'b1;
                        second_o.idx = IDX_W'(i);
                        second_o.we  = we_i[i];
                    end
                end
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Dual-port SRAM arbiter: two grants per cycle, starvation guard,
// per-requester response routing with one-cycle read latency.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 12,
    parameter int NUM_REQ      = 3,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ-1:0]            req_we,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [NUM_REQ*DATA_WIDTH-1:0] rsp_rdata,
    output logic [ADDR_WIDTH-1:0]         mem_a_addr,
    output logic                          mem_a_we,
    output logic [DATA_WIDTH-1:0]         mem_a_wdata,
    input  logic [DATA_WIDTH-1:0]         mem_a_q,
    output logic [ADDR_WIDTH-1:0]         mem_b_addr,
    output logic                          mem_b_we,
    output logic [DATA_WIDTH-1:0]         mem_b_wdata,
    input  logic [DATA_WIDTH-1:0]         mem_b_q
);

    localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

    logic [7:0]            cnt_q [NUM_REQ];
    logic [7:0]            cnt_d [NUM_REQ];
    logic [NUM_REQ-1:0]    vld_m;
    logic [NUM_REQ-1:0]    urgent;
    grant_t                first;
    grant_t                second;
    grant_t                sec_ok;
    grant_t                pipe_q [2];
    logic [ADDR_WIDTH-1:0] addr_a;
    logic [ADDR_WIDTH-1:0] addr_b;
    logic [DATA_WIDTH-1:0] wd_a;
    logic [DATA_WIDTH-1:0] wd_b;
    logic                  hazard;

    // Masking with rst_n keeps ready and RAM strobes low during reset.
    assign vld_m = req_valid & {NUM_REQ{rst_n}};

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            urgent[i] = (cnt_q[i] == LIMIT);
        end
    end

    mem_arb_pick2 #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .valid_i  (vld_m),
        .urgent_i (urgent),
        .we_i     (req_we),
        .first_o  (first),
        .second_o (second)
    );

    always_comb begin
        addr_a = '0;
        addr_b = '0;
        wd_a   = '0;
        wd_b   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (first.idx == IDX_W'(i)) begin
                addr_a = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                wd_a   = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
            end
            if (second.idx == IDX_W'(i)) begin
                addr_b = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                wd_b   = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign hazard = first.vld & second.vld & (addr_a == addr_b)
                  & (first.we | second.we);

    always_comb begin
        sec_ok     = second;
        sec_ok.vld = second.vld & ~hazard;
    end

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            req_ready[i] = (first.vld && first.idx == IDX_W'(i))
                        || (sec_ok.vld && sec_ok.idx == IDX_W'(i));
        end
    end

    assign mem_a_addr  = first.vld ? addr_a : '0;
    assign mem_a_we    = first.vld & first.we;
    assign mem_a_wdata = first.vld ? wd_a : '0;
    assign mem_b_addr  = sec_ok.vld ? addr_b : '0;
    assign mem_b_we    = sec_ok.vld & sec_ok.we;
    assign mem_b_wdata = sec_ok.vld ? wd_b : '0;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!req_valid[i] || req_ready[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] != LIMIT) begin
                cnt_d[i] = cnt_q[i] + 8'd1;
            end else begin
                cnt_d[i] = cnt_q[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                cnt_q[i] <= '0;
            end
            pipe_q[PORT_A] <= '0;
            pipe_q[PORT_B] <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            pipe_q[PORT_A] <= first;
            pipe_q[PORT_B] <= sec_ok;
        end
    end

    // A requester owns at most one port per cycle, so the two hits never collide.
    always_comb begin
        rsp_valid = '0;
        rsp_rdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pipe_q[PORT_A].vld && pipe_q[PORT_A].idx == IDX_W'(i)) begin
                rsp_valid[i] = 1'b1;
                if (!pipe_q[PORT_A].we) begin
                    rsp_rdata[i*DATA_WIDTH +: DATA_WIDTH] = mem_a_q;
                end
            end
            if (pipe_q[PORT_B].vld && pipe_q[PORT_B].idx == IDX_W'(i)) begin
                rsp_valid[i] = 1'b1;
                if (!pipe_q[PORT_B].we) begin
                    rsp_rdata[i*DATA_WIDTH +: DATA_WIDTH] = mem_b_q;
                end
            end
        end
    end

endmodule
